// File: rtl/unidade_pc_desvio.sv
// Program-counter and branch-resolution stage of the nRISC core: advances or redirects the PC,
// pulses the COND-register clear, inserts a flush bubble after taken branches and implements HALT.
module unidade_pc_desvio #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 br_uncond,
    input  logic                 br_cond,
    input  logic                 halt,
    input  logic [PC_WIDTH-1:0]  alvo,
    input  logic                 cond_atual,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 reset_cond,
    output logic                 flush,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] desvios_tomados
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t               state_q;
    logic [PC_WIDTH-1:0]  pc_q;
    logic                 reset_cond_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [PC_WIDTH-1:0]  pc_seq_d;
    logic [CNT_WIDTH-1:0] cnt_inc_d;
    logic                 taken;

    // Sequential PC wraps naturally at the register width.
    assign pc_seq_d  = pc_q + 1'b1;
    assign cnt_inc_d = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign taken     = br_uncond || (br_cond && cond_atual);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= '0;
            reset_cond_q <= 1'b0;
            cnt_q        <= '0;
        end else if (!enable) begin
            reset_cond_q <= 1'b0;
        end else begin
            reset_cond_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (taken) begin
                        pc_q    <= alvo;
                        state_q <= ST_FLUSH;
                        cnt_q   <= cnt_inc_d;
                    end else if (!br_uncond && !br_cond && halt) begin
                        state_q <= ST_HALT;
                    end else begin
                        pc_q <= pc_seq_d;
                    end
                    // The clear pulse follows any conditional branch that won priority, taken or not.
                    if (!br_uncond && br_cond) begin
                        reset_cond_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_RUN;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign pc              = pc_q;
    assign reset_cond      = reset_cond_q;
    assign flush           = (state_q == ST_FLUSH);
    assign halted          = (state_q == ST_HALT);
    assign desvios_tomados = cnt_q;

endmodule

// File: tb/tb_unidade_pc_desvio.sv
// Bench for unidade_pc_desvio: an abstract reference model checked every cycle, plus
// directed vectors with hand-computed literals; a second instance exercises counter saturation.
module tb_unidade_pc_desvio;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       br_uncond;
    logic       br_cond;
    logic       halt;
    logic [7:0] alvo;
    logic       cond_atual;

    logic [7:0] pc8, pc2;
    logic       rc8, rc2, fl8, fl2, hl8, hl2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Reference model: plain integers and flags
    int m_pc;
    bit m_bubble;
    bit m_halted;
    bit m_rc;
    int m_taken;

    always #5 clk = ~clk;

    unidade_pc_desvio #(.PC_WIDTH(8), .CNT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .br_uncond(br_uncond), .br_cond(br_cond),
        .halt(halt), .alvo(alvo), .cond_atual(cond_atual), .pc(pc8), .reset_cond(rc8),
        .flush(fl8), .halted(hl8), .desvios_tomados(cnt8)
    );

    unidade_pc_desvio #(.PC_WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .br_uncond(br_uncond), .br_cond(br_cond),
        .halt(halt), .alvo(alvo), .cond_atual(cond_atual), .pc(pc2), .reset_cond(rc2),
        .flush(fl2), .halted(hl2), .desvios_tomados(cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 0; m_bubble = 0; m_halted = 0; m_rc = 0; m_taken = 0;
        end else if (!enable || m_halted) begin
            m_rc = 0;
        end else if (m_bubble) begin
            m_bubble = 0;
            m_rc = 0;
        end else begin
            m_rc = br_cond && !br_uncond;
            if (br_uncond || (br_cond && cond_atual)) begin
                m_pc = alvo;
                m_bubble = 1;
                m_taken = m_taken + 1;
            end else if (!br_cond && halt) begin
                m_halted = 1;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model pc", 32'(pc8), 32'(m_pc));
            check("model pc cnt2", 32'(pc2), 32'(m_pc));
            check("model reset_cond", 32'(rc8), 32'(m_rc));
            check("model flush", 32'(fl8), 32'(m_bubble));
            check("model halted", 32'(hl8), 32'(m_halted));
            check("model cnt8", 32'(cnt8), 32'((m_taken > 255) ? 255 : m_taken));
            check("model cnt2", 32'(cnt2), 32'((m_taken > 3) ? 3 : m_taken));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        br_uncond = 0; br_cond = 0; halt = 0; cond_atual = 0;
    endtask

    task automatic jump_to(input logic [7:0] target);
        br_uncond = 1; alvo = target;
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1; enable = 1; alvo = 8'h00;
        idle_inputs();
        tick();
        tick();
        cmp_en = 1;
        check("reset pc", 32'(pc8), 0);
        check("reset flush", 32'(fl8), 0);
        check("reset reset_cond", 32'(rc8), 0);
        check("reset cnt", 32'(cnt8), 0);
        check("reset halted", 32'(hl8), 0);

        reset = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("idle pc", 32'(pc8), 32'(i));
        end
        for (int i = 0; i < 11; i++) tick();
        check("pc at 0x10", 32'(pc8), 32'h10);

        // Taken conditional branch
        br_cond = 1; cond_atual = 1; alvo = 8'h40;
        tick();
        idle_inputs();
        check("taken pc", 32'(pc8), 32'h40);
        check("taken flush", 32'(fl8), 1);
        check("taken reset_cond", 32'(rc8), 1);
        check("taken cnt", 32'(cnt8), 1);
        tick();
        check("flush end flush", 32'(fl8), 0);
        check("flush end pc", 32'(pc8), 32'h40);
        check("flush end reset_cond", 32'(rc8), 0);
        tick();
        check("after flush pc", 32'(pc8), 32'h41);

        // Not-taken conditional branches, back to back
        jump_to(8'h10);
        br_cond = 1; cond_atual = 0;
        tick();
        check("not taken pc", 32'(pc8), 32'h11);
        check("not taken reset_cond", 32'(rc8), 1);
        check("not taken flush", 32'(fl8), 0);
        check("not taken cnt", 32'(cnt8), 2);
        tick();
        check("b2b reset_cond", 32'(rc8), 1);
        check("b2b pc", 32'(pc8), 32'h12);
        idle_inputs();
        tick();
        check("pulse ends", 32'(rc8), 0);

        // Wrap and priority br_uncond over br_cond
        jump_to(8'hFF);
        tick();
        check("wrap pc", 32'(pc8), 32'h00);
        br_uncond = 1; br_cond = 1; cond_atual = 0; alvo = 8'h22;
        tick();
        idle_inputs();
        check("prio pc", 32'(pc8), 32'h22);
        check("prio reset_cond", 32'(rc8), 0);
        check("prio flush", 32'(fl8), 1);
        check("prio cnt", 32'(cnt8), 4);
        tick();

        // Stall in RUN and stall during FLUSH
        enable = 0;
        tick();
        check("stall run pc", 32'(pc8), 32'h22);
        enable = 1;
        br_cond = 1; cond_atual = 1; alvo = 8'h30;
        tick();
        idle_inputs();
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall flush", 32'(fl8), 1);
            check("stall pc", 32'(pc8), 32'h30);
            check("stall reset_cond", 32'(rc8), 0);
        end
        enable = 1;
        tick();
        check("stall exit flush", 32'(fl8), 0);
        check("stall exit pc", 32'(pc8), 32'h30);
        tick();
        check("stall resume pc", 32'(pc8), 32'h31);

        // HALT ignores jumps; only reset exits
        jump_to(8'h07);
        halt = 1;
        tick();
        halt = 0;
        check("halted", 32'(hl8), 1);
        check("halt pc", 32'(pc8), 32'h07);
        for (int i = 0; i < 3; i++) begin
            br_uncond = 1; alvo = 8'h55;
            tick();
            br_uncond = 0;
            tick();
            check("halt hold pc", 32'(pc8), 32'h07);
            check("halt hold state", 32'(hl8), 1);
        end
        check("halt cnt", 32'(cnt8), 6);
        reset = 1;
        tick();
        reset = 0;
        check("halt reset pc", 32'(pc8), 0);
        check("halt reset halted", 32'(hl8), 0);
        check("halt reset cnt", 32'(cnt8), 0);

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) jump_to(8'(8'h80 + i));
        check("sat cnt2", 32'(cnt2), 3);
        check("sat cnt8", 32'(cnt8), 5);
        tick();

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
